pipe_skid_buf: RTL

- Two-entry valid/ready skid buffer (pipeline register slice) sitting directly upstream of the stall-capable pipeline registers.
- Accepts words from a producer on a valid/ready handshake and presents them to the downstream stage.
- Generates `m_en`, which drives the `en` input of downstream stall-mode registers.
- Breaks the combinational ready path: `s_ready` is a flop output with no path from `m_ready`.

---
 rtl/pipe_skid_buf.sv | 114 +++++++++++
 1 files changed

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: two-entry valid/ready skid buffer (register slice).
// Both s_ready and m_valid come straight from flops, so there is no
// combinational path from m_ready to s_ready. m_en = m_valid & m_ready
// drives the enable of the downstream stall-mode registers.
// Optional: define PIPE_SKID_BUF_STAT_EN to enable a saturating counter of
// producer-stall cycles on stall_cnt. When it is undefined, stall_cnt is 0.
module pipe_skid_buf #(
    parameter int                  data_wid = 32,
    parameter logic [data_wid-1:0] rst_val  = '0,
    parameter int                  stat_wid = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [data_wid-1:0] s_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [data_wid-1:0] m_data,
    output logic                m_en,
    output logic [stat_wid-1:0] stall_cnt
);

    // 2'b11 is unused. If it is ever reached, it recovers to EMPTY.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic [data_wid-1:0] main_q, main_d;
    logic [data_wid-1:0] skid_q, skid_d;
    logic                m_valid_q, m_valid_d;
    logic                s_ready_q, s_ready_d;
    logic                s_xfer;

    assign s_xfer  = s_valid & s_ready_q;
    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = main_q;
    assign m_en    = m_valid_q & m_ready;

    // Next-state, data-load and registered-output decode
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (s_xfer) begin
                    state_d = ST_BUSY;
                    main_d  = s_data;
                end
            end
            ST_BUSY: begin
                if (s_xfer && m_ready) begin
                    main_d = s_data;              // pass-through, skid unused
                end else if (s_xfer) begin
                    state_d = ST_FULL;
                    skid_d  = s_data;             // consumer stalled: park new word
                end else if (m_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // s_ready is low here, so no producer transfer can occur
                if (m_ready) begin
                    state_d = ST_BUSY;
                    main_d  = skid_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        m_valid_d = (state_d == ST_BUSY) || (state_d == ST_FULL);
        s_ready_d = (state_d != ST_FULL);
    end

    // State, storage and output flops. Reset discards all held words.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            main_q    <= rst_val;
            skid_q    <= rst_val;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            m_valid_q <= m_valid_d;
            s_ready_q <= s_ready_d;
        end
    end

`ifdef PIPE_SKID_BUF_STAT_EN
    localparam logic [stat_wid-1:0] STAT_ONE = 1;
    logic [stat_wid-1:0] stall_q;

    // Count cycles in which the producer is blocked; saturate at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (s_valid && !s_ready_q && (stall_q != '1)) begin
            stall_q <= stall_q + STAT_ONE;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
